// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority encoder / arbiter: mode encodings and
// the index-width helper used to size the encoded output.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 with a floor of 1, so a single request line still gets a
  // one-bit index port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prio_select.sv
// Combinational request selector. Fixed mode picks the highest set index;
// round-robin mode picks the first set bit strictly after i_start, wrapping
// from N-1 back to 0. Also reports whether anything is set and whether more
// than one candidate competed.
module prio_select
  import prio_enc_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  input  logic         i_rr,
  output logic [W-1:0] o_idx,
  output logic [N-1:0] o_onehot,
  output logic         o_any,
  output logic         o_multi
);

  logic [W-1:0] w_idx;
  logic         w_any;
  int           w_cnt;
  int           w_pos;

  // Scan the candidate vector and resolve the winner for the active mode.
  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    w_cnt = 0;
    w_pos = 0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) w_cnt = w_cnt + 1;
    end
    if (!i_rr) begin
      // Ascending scan; the last hit is the highest index.
      for (int i = 0; i < N; i++) begin
        if (i_vec[i]) begin
          w_idx = W'(i);
          w_any = 1'b1;
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest hit after
      // i_start is the one that sticks.
      for (int k = N; k >= 1; k--) begin
        w_pos = (int'(i_start) + k) % N;
        if (i_vec[w_pos]) begin
          w_idx = W'(w_pos);
          w_any = 1'b1;
        end
      end
    end
  end

  assign o_idx    = w_idx;
  assign o_any    = w_any;
  assign o_onehot = w_any ? (N'(1) << w_idx) : '0;
  assign o_multi  = (w_cnt > 1);

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered N-to-log2(N) priority encoder with sticky request capture,
// fixed or round-robin arbitration, and a valid/ready output slot.
module prio_encoder_arb
  import prio_enc_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         mode_i,
  input  logic         clear_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] enc_o,
  output logic [N-1:0] onehot_o,
  output logic         multi_o
);

  logic [N-1:0] r_pending;
  logic         r_valid;
  logic [W-1:0] r_enc;
  logic [N-1:0] r_onehot;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_cand;
  logic         w_load;
  logic [W-1:0] w_sel_idx;
  logic [N-1:0] w_sel_onehot;
  logic         w_sel_any;
  logic         w_sel_multi;

  // Requests already captured plus anything arriving this cycle compete.
  assign w_cand = r_pending | req_i;
  // The output slot can take a new value when empty or being accepted.
  assign w_load = !r_valid || ready_i;

  prio_select #(.N(N)) u_select (
    .i_vec    (w_cand),
    .i_start  (r_ptr),
    .i_rr     (mode_i == MODE_RR),
    .o_idx    (w_sel_idx),
    .o_onehot (w_sel_onehot),
    .o_any    (w_sel_any),
    .o_multi  (w_sel_multi)
  );

  // Capture requests, load the output slot, and advance the round-robin
  // pointer. Clear dominates everything except reset; the pointer survives it.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_enc     <= '0;
      r_onehot  <= '0;
      r_multi   <= 1'b0;
      r_ptr     <= W'(N - 1);
    end else if (clear_i) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_enc     <= '0;
      r_onehot  <= '0;
      r_multi   <= 1'b0;
    end else if (w_load) begin
      r_valid   <= w_sel_any;
      r_enc     <= w_sel_idx;
      r_onehot  <= w_sel_onehot;
      r_multi   <= w_sel_multi;
      r_pending <= w_cand & ~w_sel_onehot;
      if (w_sel_any) r_ptr <= w_sel_idx;
    end else begin
      // Slot is stalled: hold the presented value, keep accumulating.
      r_pending <= w_cand;
    end
  end

  assign valid_o  = r_valid;
  assign enc_o    = r_enc;
  assign onehot_o = r_onehot;
  assign multi_o  = r_multi;

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Self-checking bench for prio_encoder_arb: an N=4 and an N=5 instance,
// directed table vectors, hand sequences for stall/clear/async reset, and a
// randomized run scored against a behavioural model.
module tb_prio_encoder_arb;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic       clear;
  logic       ready;
  logic [3:0] req4;
  logic [4:0] req5;

  logic       valid4, multi4;
  logic [1:0] enc4;
  logic [3:0] oh4;
  logic       valid5, multi5;
  logic [2:0] enc5;
  logic [4:0] oh5;

  int n_pass  = 0;
  int n_total = 0;

  prio_encoder_arb #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4), .mode_i(mode), .clear_i(clear),
    .ready_i(ready), .valid_o(valid4), .enc_o(enc4), .onehot_o(oh4), .multi_o(multi4)
  );

  prio_encoder_arb #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_i(req5), .mode_i(mode), .clear_i(clear),
    .ready_i(ready), .valid_o(valid5), .enc_o(enc5), .onehot_o(oh5), .multi_o(multi5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit [7:0] pend;
    bit       valid;
    int       enc;
    bit [7:0] oh;
    bit       multi;
    int       ptr;
  } model_t;

  model_t m4, m5;

  function automatic model_t model_init(int n);
    model_t r;
    r.pend = 0; r.valid = 0; r.enc = 0; r.oh = 0; r.multi = 0; r.ptr = n - 1;
    return r;
  endfunction

  // One clock edge of the arbiter, expressed from the behavioural rules.
  function automatic model_t model_step(model_t s, int n, bit [7:0] req,
                                        bit md, bit clr, bit rdy);
    model_t   r;
    bit [7:0] cand;
    int       sel;
    r    = s;
    cand = (s.pend | req) & 8'((1 << n) - 1);
    if (clr) begin
      r.pend = 0; r.valid = 0; r.oh = 0; r.multi = 0;
      return r;
    end
    if (s.valid && !rdy) begin
      r.pend = cand;
      return r;
    end
    sel = -1;
    if (!md) begin
      for (int i = n - 1; i >= 0; i--)
        if (sel < 0 && cand[i]) sel = i;
    end else begin
      for (int off = 1; off <= n; off++)
        if (sel < 0 && cand[(s.ptr + off) % n]) sel = (s.ptr + off) % n;
    end
    if (sel < 0) begin
      r.valid = 0; r.enc = 0; r.oh = 0; r.multi = 0; r.pend = 0;
    end else begin
      r.valid = 1;
      r.enc   = sel;
      r.oh    = 8'(1 << sel);
      r.multi = ($countones(cand) > 1);
      r.pend  = cand & ~(8'(1 << sel));
      r.ptr   = sel;
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one cycle from a falling edge, advance models, land on next falling edge.
  task automatic step(input logic [3:0] r4, input logic [4:0] r5,
                      input logic md, input logic clr, input logic rdy);
    req4 = r4; req5 = r5; mode = md; clear = clr; ready = rdy;
    m4 = model_step(m4, 4, {4'b0, r4}, md, clr, rdy);
    m5 = model_step(m5, 5, {3'b0, r5}, md, clr, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req4 = '0; req5 = '0; mode = 1'b0; clear = 1'b0; ready = 1'b0;
    m4 = model_init(4);
    m5 = model_init(5);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_v4"}, int'(valid4), int'(m4.valid));
    check({tag, "_oh4"}, int'(oh4), int'(m4.oh));
    check({tag, "_m4"}, int'(multi4), int'(m4.multi));
    if (m4.valid) check({tag, "_e4"}, int'(enc4), m4.enc);
    check({tag, "_v5"}, int'(valid5), int'(m5.valid));
    check({tag, "_oh5"}, int'(oh5), int'(m5.oh));
    check({tag, "_m5"}, int'(multi5), int'(m5.multi));
    if (m5.valid) check({tag, "_e5"}, int'(enc5), m5.enc);
    check({tag, "_e5_range"}, int'(enc5 <= 3'd4), 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       md;
    logic       rdy;
    logic       exp_v;
    int         exp_enc;
    logic [3:0] exp_oh;
    logic       exp_m;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Fixed priority, one-cycle 1010 pulse, consumer always ready.
    tbl[0] = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 3, 4'b1000, 1'b1};
    tbl[1] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1, 4'b0010, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0};
    // Round-robin, all requests held, consumer always ready.
    tbl[3] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 1'b1};
    tbl[4] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1, 4'b0010, 1'b1};
    tbl[5] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 1'b1};
    tbl[6] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 3, 4'b1000, 1'b1};
    tbl[7] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 1'b1};
    tbl[8] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1, 4'b0010, 1'b1};

    rst_n = 1'b0;
    req4 = '0; req5 = '0; mode = 1'b0; clear = 1'b0; ready = 1'b0;
    m4 = model_init(4);
    m5 = model_init(5);

    // Reset values, and they persist with no requests.
    #2;
    check("rst_valid", int'(valid4), 0);
    check("rst_enc", int'(enc4), 0);
    check("rst_onehot", int'(oh4), 0);
    check("rst_multi", int'(multi4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    check("idle_valid", int'(valid4), 0);
    check("idle_onehot", int'(oh4), 0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req, 5'b0, tbl[i].md, 1'b0, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), int'(valid4), int'(tbl[i].exp_v));
      if (tbl[i].exp_v) check($sformatf("tbl%0d_enc", i), int'(enc4), tbl[i].exp_enc);
      check($sformatf("tbl%0d_onehot", i), int'(oh4), int'(tbl[i].exp_oh));
      check($sformatf("tbl%0d_multi", i), int'(multi4), int'(tbl[i].exp_m));
    end

    // Backpressure: first request held while a later one accumulates.
    do_reset();
    step(4'b0001, 5'b0, 1'b0, 1'b0, 1'b0);
    check("bp_first_enc", int'(enc4), 0);
    check("bp_first_valid", int'(valid4), 1);
    step(4'b0100, 5'b0, 1'b0, 1'b0, 1'b0);
    check("bp_hold_enc", int'(enc4), 0);
    check("bp_hold_onehot", int'(oh4), 1);
    step(4'b0000, 5'b0, 1'b0, 1'b0, 1'b0);
    check("bp_hold2_enc", int'(enc4), 0);
    step(4'b0000, 5'b0, 1'b0, 1'b0, 1'b1);
    check("bp_next_enc", int'(enc4), 2);
    check("bp_next_valid", int'(valid4), 1);
    check("bp_next_multi", int'(multi4), 0);
    step(4'b0000, 5'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drain_valid", int'(valid4), 0);

    // Clear with a presented request, pending bits and a same-cycle request.
    do_reset();
    step(4'b0001, 5'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0110, 5'b0, 1'b0, 1'b0, 1'b0);
    check("clr_pre_valid", int'(valid4), 1);
    step(4'b0001, 5'b0, 1'b0, 1'b1, 1'b0);
    check("clr_valid", int'(valid4), 0);
    check("clr_onehot", int'(oh4), 0);
    check("clr_multi", int'(multi4), 0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 5'b0, 1'b0, 1'b0, 1'b1);
      check($sformatf("clr_after%0d_valid", i), int'(valid4), 0);
    end

    // N=5 round-robin with bits 0 and 4 held: alternates across the wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(4'b0, 5'b10001, 1'b1, 1'b0, 1'b1);
      check($sformatf("n5_rr%0d_enc", i), int'(enc5), (i % 2 == 0) ? 0 : 4);
      check($sformatf("n5_rr%0d_valid", i), int'(valid5), 1);
      check($sformatf("n5_rr%0d_multi", i), int'(multi5), 1);
    end
    // Async reset between edges clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("n5_async_valid", int'(valid5), 0);
    check("n5_async_onehot", int'(oh5), 0);
    check("n5_async_enc", int'(enc5), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m4 = model_init(4);
    m5 = model_init(5);
    req5 = '0;

    // Randomized run on both instances against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      cmp_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
